spi_flash_responder: RTL and testbench

Synthesizable SPI mode-0 responder: the flash-side end of the serial link that `spi_block` drives. Emulates the subset of an S25FL032P that the C64 boot path uses: READ (0x03) and READ-ID (0x9F). Samples SCK/CS/MOSI in the system clock domain and serves read data from a byte-wide on-chip memory port, so flash reads work in hardware and simulation without the vendor model.

---
 rtl/spi_flash_responder.sv | 199 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder serving READ (0x03) and READ-ID (0x9F)
// from a byte-wide memory port, all logic in the system clock domain.
module spi_flash_responder #(
   parameter logic [23:0] JEDEC_ID = 24'h010215,
   parameter int          ADDR_W   = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              chip_select,
   input  logic              data_clk,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              busy,
   output logic              cmd_error
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_ID   = 3'd4;
   localparam logic [2:0] S_IGN  = 3'd5;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic       cs_s1, cs_s2, cs_s3;
   logic       sck_s1, sck_s2, sck_s3;
   logic       mosi_s1, mosi_s2;
   logic       sck_rise, sck_fall, cs_fall, cs_rise;

   logic [2:0] state;
   logic [4:0] cnt;
   logic [7:0] rx;
   logic [7:0] tx;
   logic [7:0] pf;
   logic       pf_valid;
   logic       rd_d;
   logic       skip;
   logic [1:0] id_idx;
   logic [1:0] id_nxt;
   logic [7:0] rx_next;

   assign sck_rise = sck_s2 & ~sck_s3;
   assign sck_fall = ~sck_s2 & sck_s3;
   assign cs_fall  = ~cs_s2 & cs_s3;
   assign cs_rise  = cs_s2 & ~cs_s3;
   assign rx_next  = {rx[6:0], mosi_s2};
   assign id_nxt   = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;

   assign miso_oe = (state == S_DATA) || (state == S_ID);
   assign miso    = miso_oe ? tx[7] : 1'b0;
   assign busy    = (state != S_IDLE);

   function automatic logic [7:0] id_byte(input logic [1:0] i);
      case (i)
         2'd0:    id_byte = JEDEC_ID[23:16];
         2'd1:    id_byte = JEDEC_ID[15:8];
         default: id_byte = JEDEC_ID[7:0];
      endcase
   endfunction

   // Bring the SPI pins into the clk domain; CS idles high.
   always_ff @(posedge clk) begin
      if (reset) begin
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_s3   <= 1'b1;
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_s3  <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
      end else begin
         cs_s1   <= chip_select;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
         sck_s1  <= data_clk;
         sck_s2  <= sck_s1;
         sck_s3  <= sck_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
      end
   end

   // Command/address/data sequencing; the fall closing the last
   // header clock is skipped so bit 7 stays up for the next rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rx        <= '0;
         tx        <= '0;
         pf        <= '0;
         pf_valid  <= 1'b0;
         rd_d      <= 1'b0;
         skip      <= 1'b0;
         id_idx    <= '0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         cmd_error <= 1'b0;
      end else begin
         mem_rd    <= 1'b0;
         cmd_error <= 1'b0;
         rd_d      <= mem_rd;
         if (cs_rise) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pf_valid <= 1'b0;
            skip     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cs_fall) begin
                     state <= S_CMD;
                     cnt   <= '0;
                     rx    <= '0;
                  end
               end
               S_CMD: begin
                  if (sck_rise) begin
                     rx  <= rx_next;
                     cnt <= cnt + 5'd1;
                     if (cnt == 5'd7) begin
                        cnt <= '0;
                        if (rx_next == 8'h03) begin
                           state <= S_ADDR;
                        end else if (rx_next == 8'h9F) begin
                           state  <= S_ID;
                           tx     <= JEDEC_ID[23:16];
                           id_idx <= 2'd0;
                           skip   <= 1'b1;
                        end else begin
                           state     <= S_IGN;
                           cmd_error <= 1'b1;
                        end
                     end
                  end
               end
               S_ADDR: begin
                  if (rd_d) begin
                     tx       <= mem_data;
                     mem_addr <= mem_addr + ADDR_ONE;
                     mem_rd   <= 1'b1;
                     pf_valid <= 1'b0;
                     skip     <= 1'b1;
                     cnt      <= '0;
                     state    <= S_DATA;
                  end else if (sck_rise && cnt != 5'd24) begin
                     mem_addr <= {mem_addr[ADDR_W-2:0], mosi_s2};
                     cnt      <= cnt + 5'd1;
                     if (cnt == 5'd23) mem_rd <= 1'b1;
                  end
               end
               S_DATA: begin
                  if (rd_d) begin
                     pf       <= mem_data;
                     pf_valid <= 1'b1;
                  end
                  if (sck_fall) begin
                     if (skip) begin
                        skip <= 1'b0;
                     end else if (cnt == 5'd7) begin
                        cnt      <= '0;
                        tx       <= pf_valid ? pf : 8'h00;
                        pf_valid <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_ONE;
                     end else begin
                        cnt <= cnt + 5'd1;
                        tx  <= {tx[6:0], 1'b0};
                     end
                  end
               end
               S_ID: begin
                  if (sck_fall) begin
                     if (skip) begin
                        skip <= 1'b0;
                     end else if (cnt == 5'd7) begin
                        cnt    <= '0;
                        id_idx <= id_nxt;
                        tx     <= id_byte(id_nxt);
                     end else begin
                        cnt <= cnt + 5'd1;
                        tx  <= {tx[6:0], 1'b0};
                     end
                  end
               end
               S_IGN: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder: a mode-0 master model
// drives the pins, expected bytes come from a memory/ID model.
module tb_spi_flash_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        chip_select;
   logic        data_clk;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic [23:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data = 8'h00;
   logic        busy;
   logic        cmd_error;

   int tests = 0;
   int fails = 0;
   int rd_cnt = 0;
   int err_cnt = 0;
   int oe_cnt = 0;
   logic [7:0] key = 8'h00;
   logic [7:0] id_tab [3] = '{8'h01, 8'h02, 8'h15};

   always #20 clk = ~clk;

   spi_flash_responder dut (
      .clk(clk),
      .reset(reset),
      .chip_select(chip_select),
      .data_clk(data_clk),
      .mosi(mosi),
      .miso(miso),
      .miso_oe(miso_oe),
      .mem_addr(mem_addr),
      .mem_rd(mem_rd),
      .mem_data(mem_data),
      .busy(busy),
      .cmd_error(cmd_error)
   );

   // Flash contents as a pure function of address and a per-test key.
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ key;
   endfunction

   // Synchronous memory: data the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd === 1'b1) begin
         mem_data <= mem_byte(mem_addr);
         rd_cnt   <= rd_cnt + 1;
      end
      if (cmd_error === 1'b1) err_cnt <= err_cnt + 1;
   end

   // Count cycles in which the responder drives miso.
   always @(negedge clk) begin
      if (miso_oe === 1'b1) oe_cnt <= oe_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer_bit(input logic o, output logic r);
      mosi = o;
      tick(6);
      r = miso;
      data_clk = 1'b1;
      tick(6);
      data_clk = 1'b0;
   endtask

   task automatic xfer(input logic [7:0] o, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) xfer_bit(o[i], r[i]);
   endtask

   task automatic cs_start();
      chip_select = 1'b0;
      tick(6);
   endtask

   task automatic cs_stop();
      tick(6);
      chip_select = 1'b1;
      tick(8);
   endtask

   task automatic send_read_hdr(input logic [23:0] a);
      logic [7:0] d;
      xfer(8'h03, d);
      xfer(a[23:16], d);
      xfer(a[15:8], d);
      xfer(a[7:0], d);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      chip_select = 1'b1;
      data_clk = 1'b0;
      mosi = 1'b0;
      tick(4);
      reset = 1'b0;
      tick(4);
      tests++;
      if ({miso, miso_oe, mem_rd, busy, cmd_error, mem_addr} !== 29'd0) begin
         fails++;
         $display("FAIL reset_values: got oe=%b busy=%b rd=%b err=%b addr=%h, want all 0",
                  miso_oe, busy, mem_rd, cmd_error, mem_addr);
      end
   endtask

   // Reads n bytes from address a and checks each against the model.
   task automatic test_read_at(input logic [23:0] a, input int n);
      logic [7:0]  b;
      logic [23:0] ai;
      int r0;
      r0 = rd_cnt;
      cs_start();
      send_read_hdr(a);
      for (int i = 0; i < n; i++) begin
         xfer(8'h00, b);
         ai = a + 24'(i);
         tests++;
         if (b !== mem_byte(ai)) begin
            fails++;
            $display("FAIL read_byte @%h: got %h, want %h", ai, b, mem_byte(ai));
         end
      end
      tests++;
      if (miso_oe !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL read_oe_busy: got oe=%b busy=%b, want 1 1", miso_oe, busy);
      end
      cs_stop();
      tests++;
      if (rd_cnt - r0 < n + 1 || rd_cnt - r0 > n + 2) begin
         fails++;
         $display("FAIL read_count: got %0d reads for %0d bytes, want %0d..%0d",
                  rd_cnt - r0, n, n + 1, n + 2);
      end
   endtask

   task automatic test_read();
      key = 8'h00;
      test_read_at(24'h000010, 2);
      cs_start();
      send_read_hdr(24'h000010);
      tick(6);
      chip_select = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      tests++;
      if (miso_oe !== 1'b1) begin
         fails++;
         $display("FAIL oe_hold: got oe=%b 2 cycles after CS rise, want 1", miso_oe);
      end
      @(posedge clk);
      #1;
      tests++;
      if (miso_oe !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL oe_drop: got oe=%b busy=%b 3 cycles after CS rise, want 0 0",
                  miso_oe, busy);
      end
      tick(8);
   endtask

   task automatic test_id(input int nbytes);
      logic [7:0] b;
      int r0;
      r0 = rd_cnt;
      cs_start();
      xfer(8'h9F, b);
      for (int i = 0; i < nbytes; i++) begin
         xfer(8'h00, b);
         tests++;
         if (b !== id_tab[i % 3]) begin
            fails++;
            $display("FAIL id_byte %0d: got %h, want %h", i, b, id_tab[i % 3]);
         end
      end
      cs_stop();
      tests++;
      if (rd_cnt != r0) begin
         fails++;
         $display("FAIL id_no_read: got %0d reads, want 0", rd_cnt - r0);
      end
   endtask

   task automatic test_wrap();
      key = 8'($urandom);
      test_read_at(24'hFFFFFF, 2);
   endtask

   task automatic test_bad_opcode();
      logic [7:0] b;
      int e0, o0;
      e0 = err_cnt;
      o0 = oe_cnt;
      cs_start();
      xfer(8'hAB, b);
      for (int i = 0; i < 3; i++) xfer(8'($urandom), b);
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL bad_busy: got %b, want 1", busy);
      end
      cs_stop();
      tests++;
      if (err_cnt - e0 != 1) begin
         fails++;
         $display("FAIL bad_err_pulse: got %0d pulses, want 1", err_cnt - e0);
      end
      tests++;
      if (oe_cnt != o0) begin
         fails++;
         $display("FAIL bad_oe: got %0d driven cycles, want 0", oe_cnt - o0);
      end
      test_id(1);
   endtask

   task automatic test_abort();
      logic [7:0] b;
      logic       r;
      cs_start();
      xfer(8'h03, b);
      xfer(8'hFF, b);
      for (int i = 0; i < 4; i++) xfer_bit(1'b1, r);
      cs_stop();
      key = 8'($urandom);
      test_read_at(24'h000100, 1);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      logic       r;
      key = 8'($urandom);
      cs_start();
      send_read_hdr(24'($urandom));
      xfer(8'h00, b);
      for (int i = 0; i < 3; i++) xfer_bit(1'b0, r);
      reset = 1'b1;
      tick(1);
      tests++;
      if ({miso, miso_oe, mem_rd, busy, cmd_error, mem_addr} !== 29'd0) begin
         fails++;
         $display("FAIL reset_mid: got oe=%b busy=%b rd=%b err=%b addr=%h, want all 0",
                  miso_oe, busy, mem_rd, cmd_error, mem_addr);
      end
      reset = 1'b0;
      chip_select = 1'b1;
      tick(10);
      test_read_at(24'($urandom), 2);
   endtask

   task automatic test_random();
      logic [23:0] a;
      for (int k = 0; k < 6; k++) begin
         key = 8'($urandom);
         a = (k % 2 == 0) ? 24'($urandom) : 24'hFFFFFF - 24'($urandom_range(0, 3));
         test_read_at(a, $urandom_range(1, 4));
      end
      test_id($urandom_range(2, 7));
   endtask

   initial begin
      test_reset();
      test_read();
      test_id(4);
      test_wrap();
      test_bad_opcode();
      test_abort();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
